// File: rtl/uart_core_tx_serializer_if.sv
// rtl/uart_core_tx_serializer_if.sv - protocol-side handshake and serial line bundle for the UART transmit serializer
interface uart_core_tx_serializer_if;
    logic       PROT_CORE_ctrl_Txen;
    logic [7:0] CFG_CORE_tx_data;
    logic       USR_CORE_ctrl_cts;
    logic       CORE_CFG_r_en;
    logic       CORE_PROT_busy;
    logic       UART_txd;

    modport master (
        output PROT_CORE_ctrl_Txen,
        output CFG_CORE_tx_data,
        output USR_CORE_ctrl_cts,
        input  CORE_CFG_r_en,
        input  CORE_PROT_busy,
        input  UART_txd
    );

    modport slave (
        input  PROT_CORE_ctrl_Txen,
        input  CFG_CORE_tx_data,
        input  USR_CORE_ctrl_cts,
        output CORE_CFG_r_en,
        output CORE_PROT_busy,
        output UART_txd
    );
endinterface

// File: rtl/uart_core_tx_serializer.sv
// rtl/uart_core_tx_serializer.sv - UART transmit serializer: start, 8 data bits LSB first, optional parity, 1 or 2 stop bits
module uart_core_tx_serializer #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter bit          PARITY_EN    = 1'b0,
    parameter bit          PARITY_ODD   = 1'b0,
    parameter int unsigned STOP_BITS    = 1
) (
    input logic                      glb_clk,
    input logic                      glb_rst,
    uart_core_tx_serializer_if.slave tx_if
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic        STOP_LAST = (STOP_BITS == 2);

    logic [2:0]  state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        stop_idx_q, stop_idx_d;
    logic [7:0]  data_q, data_d;
    logic        txd_q, txd_d;
    logic        busy_q, busy_d;
    logic        r_en_q, r_en_d;

    logic        bit_end;
    logic        last_stop;
    logic        capture;
    logic        parity_bit;
    logic [2:0]  next_idx;

    assign bit_end    = (baud_q == BAUD_LAST);
    assign last_stop  = (state_q == S_STOP) && bit_end && (stop_idx_q == STOP_LAST);
    // The request is only looked at when idle or on the final stop cycle, so mid-frame changes are ignored.
    assign capture    = tx_if.PROT_CORE_ctrl_Txen && tx_if.USR_CORE_ctrl_cts &&
                        ((state_q == S_IDLE) || last_stop);
    assign parity_bit = (^data_q) ^ PARITY_ODD;
    assign next_idx   = bit_idx_q + 3'd1;

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q + 16'd1;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        data_d     = data_q;
        txd_d      = txd_q;
        busy_d     = busy_q;
        r_en_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                txd_d  = 1'b1;
                busy_d = 1'b0;
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    baud_d    = '0;
                    bit_idx_d = 3'd0;
                    txd_d     = data_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        if (PARITY_EN) begin
                            state_d = S_PARITY;
                            txd_d   = parity_bit;
                        end else begin
                            state_d    = S_STOP;
                            stop_idx_d = 1'b0;
                            txd_d      = 1'b1;
                        end
                    end else begin
                        bit_idx_d = next_idx;
                        txd_d     = data_q[next_idx];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d    = S_STOP;
                    baud_d     = '0;
                    stop_idx_d = 1'b0;
                    txd_d      = 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (stop_idx_q == STOP_LAST) begin
                        state_d = S_IDLE;
                        txd_d   = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // A capture on the last stop cycle chains straight into the next start bit.
        if (capture) begin
            state_d   = S_START;
            data_d    = tx_if.CFG_CORE_tx_data;
            baud_d    = '0;
            bit_idx_d = 3'd0;
            txd_d     = 1'b0;
            busy_d    = 1'b1;
            r_en_d    = 1'b1;
        end
    end

    always_ff @(posedge glb_clk) begin
        if (glb_rst) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            data_q     <= '0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            r_en_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            data_q     <= data_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            r_en_q     <= r_en_d;
        end
    end

    assign tx_if.UART_txd       = txd_q;
    assign tx_if.CORE_PROT_busy = busy_q;
    assign tx_if.CORE_CFG_r_en  = r_en_q;

endmodule

// File: tb/tb_uart_core_tx_serializer.sv
// tb/tb_uart_core_tx_serializer.sv - four parameterisations of the serializer driven by shared stimulus against a frame-queue model
module tb_uart_core_tx_serializer;

    logic       clk;
    logic       rst;
    logic       txen;
    logic       cts;
    logic [7:0] data;

    localparam int CPB [4] = '{4, 4, 4, 2};
    localparam int PEN [4] = '{0, 1, 1, 0};
    localparam int PODD[4] = '{0, 0, 1, 0};
    localparam int NSTP[4] = '{1, 1, 1, 2};

    uart_core_tx_serializer_if ifa ();
    uart_core_tx_serializer_if ifb ();
    uart_core_tx_serializer_if ifc ();
    uart_core_tx_serializer_if ifd ();

    assign ifa.PROT_CORE_ctrl_Txen = txen;
    assign ifa.USR_CORE_ctrl_cts   = cts;
    assign ifa.CFG_CORE_tx_data    = data;
    assign ifb.PROT_CORE_ctrl_Txen = txen;
    assign ifb.USR_CORE_ctrl_cts   = cts;
    assign ifb.CFG_CORE_tx_data    = data;
    assign ifc.PROT_CORE_ctrl_Txen = txen;
    assign ifc.USR_CORE_ctrl_cts   = cts;
    assign ifc.CFG_CORE_tx_data    = data;
    assign ifd.PROT_CORE_ctrl_Txen = txen;
    assign ifd.USR_CORE_ctrl_cts   = cts;
    assign ifd.CFG_CORE_tx_data    = data;

    uart_core_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1))
        u_a (.glb_clk(clk), .glb_rst(rst), .tx_if(ifa));
    uart_core_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(1))
        u_b (.glb_clk(clk), .glb_rst(rst), .tx_if(ifb));
    uart_core_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(1))
        u_c (.glb_clk(clk), .glb_rst(rst), .tx_if(ifc));
    uart_core_tx_serializer #(.CLKS_PER_BIT(2), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(2))
        u_d (.glb_clk(clk), .glb_rst(rst), .tx_if(ifd));

    logic txd_v[4], busy_v[4], ren_v[4];
    assign txd_v[0] = ifa.UART_txd;  assign busy_v[0] = ifa.CORE_PROT_busy; assign ren_v[0] = ifa.CORE_CFG_r_en;
    assign txd_v[1] = ifb.UART_txd;  assign busy_v[1] = ifb.CORE_PROT_busy; assign ren_v[1] = ifb.CORE_CFG_r_en;
    assign txd_v[2] = ifc.UART_txd;  assign busy_v[2] = ifc.CORE_PROT_busy; assign ren_v[2] = ifc.CORE_CFG_r_en;
    assign txd_v[3] = ifd.UART_txd;  assign busy_v[3] = ifd.CORE_PROT_busy; assign ren_v[3] = ifd.CORE_CFG_r_en;

    int checks = 0;
    int errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    // Reference: each capture enqueues the full per-cycle line waveform of the frame; the line replays it.
    logic fbits[4][64];
    int   rem[4];
    int   pos[4];
    logic m_txd[4], m_busy[4], m_ren[4];

    task automatic build_frame(input int d, input logic [7:0] b);
        logic seq[12];
        int   n;
        n = 0;
        seq[n] = 1'b0; n++;
        for (int i = 0; i < 8; i++) begin seq[n] = b[i]; n++; end
        if (PEN[d] != 0) begin seq[n] = (^b) ^ (PODD[d] != 0); n++; end
        for (int i = 0; i < NSTP[d]; i++) begin seq[n] = 1'b1; n++; end
        for (int i = 0; i < n * CPB[d]; i++) fbits[d][i] = seq[i / CPB[d]];
        rem[d] = n * CPB[d];
        pos[d] = 0;
    endtask

    always @(posedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (rst) begin
                rem[d] = 0;
                m_txd[d] <= 1'b1; m_busy[d] <= 1'b0; m_ren[d] <= 1'b0;
            end else begin
                m_ren[d] <= 1'b0;
                if (rem[d] == 0 && txen && cts) begin
                    build_frame(d, data);
                    m_ren[d] <= 1'b1;
                end
                if (rem[d] > 0) begin
                    m_txd[d] <= fbits[d][pos[d]];
                    m_busy[d] <= 1'b1;
                    pos[d] = pos[d] + 1;
                    rem[d] = rem[d] - 1;
                end else begin
                    m_txd[d] <= 1'b1;
                    m_busy[d] <= 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic idle_wait(input int n);
        txen = 1'b0;
        repeat (n) tick();
    endtask

    // Called one sample after the capture edge: k=0 is the first cycle of the frame.
    task automatic run_frame(input int sel, input logic [11:0] bits, input int nbits, input string name);
        int len, bad, nb, nr, rk;
        len = nbits * CPB[sel];
        bad = 0; nb = 0; nr = 0; rk = -1;
        txen = 1'b0;
        for (int k = 0; k < len + 4; k++) begin
            if (k == 10) cts = 1'b0;
            if (k == 0 || k == 10) data = ~data;
            if (txd_v[sel] !== ((k < len) ? bits[k / CPB[sel]] : 1'b1)) bad++;
            if (busy_v[sel] === 1'b1) nb++;
            if (ren_v[sel] === 1'b1) begin nr++; rk = k; end
            tick();
        end
        cts = 1'b1;
        chk({name, " txd_pattern"}, bad, 0);
        chk({name, " busy_len"}, nb, len);
        chk({name, " ren_count"}, nr, 1);
        chk({name, " ren_pos"}, rk, 0);
        idle_wait(60);
    endtask

    typedef struct {
        int          sel;
        logic [7:0]  din;
        int          nbits;
        logic [11:0] bits;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int nr, first, second, gap, bad;
        logic [9:0] rx2;

        tbl[0] = '{0, 8'hA5, 10, 12'b001101001010};
        tbl[1] = '{0, 8'h55, 10, 12'b001010101010};
        tbl[2] = '{0, 8'h00, 10, 12'b001000000000};
        tbl[3] = '{1, 8'h07, 11, 12'b011000001110};
        tbl[4] = '{2, 8'h07, 11, 12'b010000001110};
        tbl[5] = '{3, 8'h00, 11, 12'b011000000000};
        tbl[6] = '{1, 8'hFF, 11, 12'b010111111110};
        tbl[7] = '{2, 8'hFF, 11, 12'b011111111110};

        rst = 1'b1; txen = 1'b0; cts = 1'b0; data = 8'h00;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("reset_txd dut%0d", d), int'(txd_v[d]), 1);
            chk($sformatf("reset_busy dut%0d", d), int'(busy_v[d]), 0);
            chk($sformatf("reset_ren dut%0d", d), int'(ren_v[d]), 0);
        end

        for (int r = 0; r < 8; r++) begin
            txen = 1'b1; cts = 1'b1; data = tbl[r].din;
            tick();
            run_frame(tbl[r].sel, tbl[r].bits, tbl[r].nbits, $sformatf("vec%0d", r));
        end

        // Back-to-back frames with Txen held high.
        nr = 0; first = -1; second = -1; gap = 0; rx2 = '0;
        txen = 1'b1; cts = 1'b1; data = 8'h55;
        for (int k = 0; k < 130; k++) begin
            tick();
            if (ren_v[0] === 1'b1) begin
                if (nr == 0) first = k; else if (nr == 1) second = k;
                nr++;
            end
            if (nr >= 1 && k < first + 80 && busy_v[0] !== 1'b1) gap++;
            if (nr >= 2) for (int j = 0; j < 10; j++) if (k == second + 4 * j + 2) rx2[j] = txd_v[0];
            if (nr == 1) data = 8'hAA;
            if (nr >= 2) txen = 1'b0;
        end
        chk("b2b ren_count", nr, 2);
        chk("b2b ren_spacing", second - first, 40);
        chk("b2b busy_gap", gap, 0);
        chk("b2b second_frame", int'(rx2), int'(10'b1101010100));
        idle_wait(60);

        // Clear-to-send withheld for 100 cycles.
        txen = 1'b1; cts = 1'b0; data = 8'h3C; bad = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (txd_v[0] !== 1'b1 || ren_v[0] !== 1'b0 || busy_v[0] !== 1'b0) bad++;
        end
        chk("cts_hold idle_violations", bad, 0);
        cts = 1'b1;
        tick();
        chk("cts_release ren", int'(ren_v[0]), 1);
        chk("cts_release start_bit", int'(txd_v[0]), 0);
        run_frame(0, 12'b001001111000, 10, "cts_frame");

        // Reset in the middle of data bit 3, with a capture request present.
        txen = 1'b1; cts = 1'b1; data = 8'hC3;
        tick();
        txen = 1'b0;
        repeat (17) tick();
        rst = 1'b1; txen = 1'b1;
        tick();
        chk("midrst txd", int'(txd_v[0]), 1);
        chk("midrst busy", int'(busy_v[0]), 0);
        chk("midrst ren", int'(ren_v[0]), 0);
        tick();
        chk("rst_dominates ren", int'(ren_v[0]), 0);
        rst = 1'b0; data = 8'h96;
        tick();
        run_frame(0, 12'b001100101100, 10, "post_reset");

        // Randomised traffic on all four configurations against the frame-queue model.
        for (int n = 0; n < 3000; n++) begin
            rst  = ($urandom_range(0, 299) == 0);
            txen = ($urandom_range(0, 3) != 0);
            cts  = ($urandom_range(0, 7) != 0);
            data = 8'($urandom);
            tick();
            for (int d = 0; d < 4; d++)
                chk($sformatf("rand cyc%0d dut%0d txd/busy/ren", n, d),
                    int'({txd_v[d], busy_v[d], ren_v[d]}), int'({m_txd[d], m_busy[d], m_ren[d]}));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_core_tx_serializer.md
UART_CORE_TX_SERIALIZER -- requirements
Module: uart_core_tx_serializer

Interface
REQ-001 The block SHALL have one clock, glb_clk, with a synchronous active-high reset, glb_rst.
REQ-002 Parameter CLKS_PER_BIT, default 16: glb_clk cycles per serial bit; legal range 2..65535.
REQ-003 Parameter PARITY_EN, default 0: 1 inserts one parity bit after the data bits.
REQ-004 Parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity; ignored when PARITY_EN=0.
REQ-005 Parameter STOP_BITS, default 1: number of stop bits; legal values 1 and 2.
REQ-006 glb_clk  input  1  system clock, all logic on the rising edge.
REQ-007 glb_rst  input  1  synchronous active-high reset.
REQ-008 PROT_CORE_ctrl_Txen  input  1  protocol layer requests transmission of the byte currently on CFG_CORE_tx_data.
REQ-009 CFG_CORE_tx_data  input  8  byte to send: address, data or stop frame, as muxed by the protocol-layer Txsel.
REQ-010 USR_CORE_ctrl_cts  input  1  clear-to-send, active-high; gates frame start only.
REQ-011 CORE_CFG_r_en  output  1  one-cycle strobe: byte captured, upstream may advance its read pointer or state.
REQ-012 CORE_PROT_busy  output  1  high while a frame is on the line.
REQ-013 UART_txd  output  1  serial line, idle high.

Function
REQ-014 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP, all registered.
REQ-015 In IDLE, the block SHALL capture CFG_CORE_tx_data into the shift register on a rising edge where PROT_CORE_ctrl_Txen=1 and USR_CORE_ctrl_cts=1.
REQ-016 On that capture edge the block SHALL enter START and set UART_txd=0, CORE_PROT_busy=1 and CORE_CFG_r_en=1.
REQ-017 CORE_CFG_r_en SHALL be registered and high for exactly the one cycle following each capture edge; it SHALL never be high in any other cycle.
REQ-018 Every bit SHALL hold UART_txd for exactly CLKS_PER_BIT cycles, timed by a baud counter that is cleared at each capture edge and each bit boundary.
REQ-019 START SHALL drive 0; DATA SHALL drive 8 bits LSB first, using a 3-bit index from 0 to 7.
REQ-020 PARITY SHALL be present only when PARITY_EN=1, and SHALL drive the XOR of the captured byte, inverted when PARITY_ODD=1.
REQ-021 STOP SHALL drive 1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-022 Frame length SHALL be (10+PARITY_EN+STOP_BITS-1)*CLKS_PER_BIT cycles from capture edge to the end of stop.
REQ-023 At the last cycle of STOP, if Txen=1 and cts=1, the block SHALL capture the next byte on the same edge and go directly to START, with no idle gap.
REQ-024 If that back-to-back condition is not met, the block SHALL go to IDLE with CORE_PROT_busy=0 and UART_txd=1.
REQ-025 Txen, cts and CFG_CORE_tx_data SHALL be ignored while not in IDLE and not at the last STOP cycle; deasserting cts or Txen mid-frame SHALL NOT truncate the frame.
REQ-026 A change on CFG_CORE_tx_data after capture SHALL NOT alter the frame in flight.
REQ-027 Txen=1 with cts=0 SHALL hold the block in IDLE with r_en=0 indefinitely.

Reset
REQ-028 glb_rst=1 on a rising edge SHALL force state IDLE, UART_txd=1, CORE_CFG_r_en=0, CORE_PROT_busy=0, and clear the baud counter, bit index and shift register.
REQ-029 Reset mid-frame SHALL abort the frame at the next edge; no partial r_en SHALL be issued.
REQ-030 Reset SHALL dominate a simultaneous capture condition.
REQ-031 The first capture after reset release SHALL be possible on the first edge with glb_rst=0.

Verification
REQ-032 CLKS_PER_BIT=4, default parity and stop: Txen=1, cts=1, data=0xA5 for one cycle -> UART_txd = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total); r_en pulses exactly once, in cycle 1; busy high for 40 cycles.
REQ-033 PARITY_EN=1, PARITY_ODD=0, data=0x07 -> parity bit 1; with PARITY_ODD=1 -> parity bit 0; frame is 44 cycles at CLKS_PER_BIT=4.
REQ-034 Txen held high with data 0x55 then 0xAA -> two frames with no idle gap; r_en pulses exactly twice, 40 cycles apart.
REQ-035 Txen=1, cts=0 for 100 cycles, then cts=1 -> UART_txd stays 1 and r_en stays 0 throughout; the frame starts on the first edge with cts=1. Dropping cts during DATA does not alter the frame.
REQ-036 glb_rst pulsed during DATA bit 3 -> next cycle UART_txd=1, busy=0, r_en=0; a new request after release sends a full, correct frame.
REQ-037 STOP_BITS=2, CLKS_PER_BIT=2, data=0x00 -> txd low for 18 cycles, then high for 4 cycles before the next start is possible.
